// File: rtl/enc_dec_loader_pkg.sv
// Shared types and default sizing for the dual-lane block loader.
package enc_dec_loader_pkg;

    localparam int unsigned DEF_WORD_W          = 32;
    localparam int unsigned DEF_BLOCK_W         = 128;
    localparam int unsigned DEF_WORDS_PER_BLOCK = DEF_BLOCK_W / DEF_WORD_W;
    localparam int unsigned CNT_W               = $clog2(DEF_WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        XFER   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/enc_dec_block_loader_if.sv
// Word-stream input and block-pair output handshakes of the loader.
interface enc_dec_block_loader_if
    import enc_dec_loader_pkg::*;
#(
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
);
    logic [WORD_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] dataout;
    logic [BLOCK_W-1:0] dataout1;
    logic               out_valid;
    logic               out_ready;

    // Producer/consumer side (drives words, accepts pairs).
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, dataout, dataout1, out_valid
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, dataout, dataout1, out_valid
    );
endinterface

// File: rtl/enc_dec_pair_reg.sv
// Output holding register for one lane-A/lane-B block pair with valid/ready.
module enc_dec_pair_reg #(
    parameter int unsigned BLOCK_W = 128
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] data_a_i,
    input  logic [BLOCK_W-1:0] data_b_i,
    input  logic               out_ready_i,
    output logic               free_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] data_a_o,
    output logic [BLOCK_W-1:0] data_b_o
);
    logic               valid_q, valid_d;
    logic [BLOCK_W-1:0] data_a_q, data_a_d;
    logic [BLOCK_W-1:0] data_b_q, data_b_d;

    // Slot can take a new pair if empty or being drained this cycle.
    assign free_o = ~valid_q | out_ready_i;

    // Next state: load wins over drain so back-to-back pairs have no bubble.
    always_comb begin
        valid_d  = valid_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (load_i) begin
            valid_d  = 1'b1;
            data_a_d = data_a_i;
            data_b_d = data_b_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;
endmodule

// File: rtl/enc_dec_block_loader.sv
// Packs a word stream into lane-A/lane-B 128-bit block pairs for the
// encoder/decoder. Optional macro LOADER_PAD_FLUSH_EN adds a `flush` input
// that zero-pads and emits a partially filled pair.
module enc_dec_block_loader
    import enc_dec_loader_pkg::*;
#(
    parameter int unsigned WORD_W  = DEF_WORD_W,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
) (
    input logic clock,
    input logic reset,
`ifdef LOADER_PAD_FLUSH_EN
    input logic flush,
`endif
    enc_dec_block_loader_if.slave bus
);
    localparam int unsigned WPB  = BLOCK_W / WORD_W;
    localparam int unsigned CntW = (WPB > 1) ? $clog2(WPB) : 1;

    loader_state_e      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [BLOCK_W-1:0] lane_a_q, lane_a_d;
    logic [BLOCK_W-1:0] lane_b_q, lane_b_d;
    logic               in_ready_q, in_ready_d;
    logic               word_hs, last_word, slot_free, load;
    logic               pr_valid;
    logic [BLOCK_W-1:0] pr_a, pr_b;

    assign word_hs   = bus.in_valid & in_ready_q;
    assign last_word = (cnt_q == CntW'(WPB - 1));

    // FSM next state and lane assembly; lanes are cleared on transfer so
    // any slot not written before a flush is already zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_a_d = lane_a_q;
        lane_b_d = lane_b_q;
        load     = 1'b0;
        unique case (state_q)
            FILL_A: begin
                if (word_hs) begin
                    lane_a_d[cnt_q*WORD_W +: WORD_W] = bus.in_data;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = FILL_B;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            FILL_B: begin
                if (word_hs) begin
                    lane_b_d[cnt_q*WORD_W +: WORD_W] = bus.in_data;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = XFER;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            XFER: begin
                if (slot_free) begin
                    load     = 1'b1;
                    lane_a_d = '0;
                    lane_b_d = '0;
                    state_d  = FILL_A;
                end
            end
            default: state_d = FILL_A;
        endcase
`ifdef LOADER_PAD_FLUSH_EN
        // Flush only if the pair holds at least one word (counting this edge's).
        if (flush && (state_q != XFER) &&
            ((state_q == FILL_B) || (cnt_q != '0) || word_hs)) begin
            state_d = XFER;
            cnt_d   = '0;
        end
`endif
        in_ready_d = (state_d != XFER);
    end

    // FSM, counter, assembly and registered in_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL_A;
            cnt_q      <= '0;
            lane_a_q   <= '0;
            lane_b_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_a_q   <= lane_a_d;
            lane_b_q   <= lane_b_d;
            in_ready_q <= in_ready_d;
        end
    end

    enc_dec_pair_reg #(
        .BLOCK_W (BLOCK_W)
    ) u_pair_reg (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load),
        .data_a_i    (lane_a_q),
        .data_b_i    (lane_b_q),
        .out_ready_i (bus.out_ready),
        .free_o      (slot_free),
        .valid_o     (pr_valid),
        .data_a_o    (pr_a),
        .data_b_o    (pr_b)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = pr_valid;
    assign bus.dataout   = pr_a;
    assign bus.dataout1  = pr_b;
endmodule

// File: doc/enc_dec_block_loader.md
Name: enc_dec_block_loader

Overview:
- Upstream feeder for the dual-lane 128-bit encoder/decoder pair.
- Accepts a narrow word stream over a valid/ready handshake and packs it into two 128-bit blocks: lane A drives `datain`, lane B drives `datain1`.
- Presents the completed pair to the next stage with its own valid/ready handshake.
- Has one assembly stage plus one output holding register, so the next pair can fill while the current pair waits.

Parameters:
- WORD_W, 32, input word width; must divide BLOCK_W.
- BLOCK_W, 128, width of each lane block.
- WORDS_PER_BLOCK, BLOCK_W/WORD_W (4), derived; words per lane.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  WORD_W  input word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- dataout  out  BLOCK_W  lane A block (to datain).
- dataout1  out  BLOCK_W  lane B block (to datain1).
- out_valid  out  1  dataout/dataout1 hold a complete pair.
- out_ready  in  1  downstream accepts the pair.

Behaviour:
- Word handshake occurs when in_valid & in_ready at a rising edge. Pair handshake occurs when out_valid & out_ready at a rising edge.
- Reset (reset=0) is asynchronous and applies immediately:
  - in_ready=0, out_valid=0, dataout=0, dataout1=0.
  - FSM goes to FILL_A; word count=0; assembly registers cleared.
  - A partially filled pair is discarded.
- FSM states:
  - FILL_A: in_ready=1. Each accepted word is written to lane-A slot cnt, bits [cnt*WORD_W +: WORD_W]; the first word lands in [31:0]. cnt increments. When the accept has cnt==WORDS_PER_BLOCK-1, cnt wraps to 0 and the FSM goes to FILL_B.
  - FILL_B: identical, targeting lane B. The last accept goes to XFER.
  - XFER: in_ready=0. The output slot is free when out_valid==0 or out_ready==1 in the same cycle. If free, at this edge the assembly copies to dataout/dataout1, out_valid=1, and the FSM goes to FILL_A. Otherwise the FSM stays in XFER.
- Output register:
  - On a pair handshake with no simultaneous transfer, out_valid goes to 0 and the data keeps its old value.
  - A simultaneous handshake and transfer loads the new pair and out_valid stays 1 (back-to-back pairs, no bubble).
- Latency: last word accepted at edge k → out_valid=1 after edge k+1 when the slot is free. Throughput is one pair per 2*WORDS_PER_BLOCK+1 cycles.
- Backpressure: in_ready is low only in XFER and in reset. Filling continues while out_valid is held.
- in_data is ignored when in_valid=0. The outputs do not depend combinationally on in_data.
- in_ready is a registered-state decode only. It has no combinational path from out_ready.

Optional Feature:
- Macro: LOADER_PAD_FLUSH_EN.
- Defined:
  - Adds input port `flush` (1 bit).
  - `flush`=1 in FILL_A or FILL_B with at least one word accepted: at that edge, all unwritten slots of the current lane, plus lane B when in FILL_A, are zero-filled and the FSM goes to XFER.
  - If a word handshake occurs the same edge, that word is written first, then padding applies.
  - `flush` is ignored with zero words accepted, and ignored in XFER.
- Undefined: no `flush` port; only full pairs are emitted.

Decomposition:
- Package enc_dec_loader_pkg:
  - FSM state typedef: FILL_A, FILL_B, XFER.
  - Default WORD_W/BLOCK_W constants.
  - Count width constant $clog2(WORDS_PER_BLOCK).
- Sub-module enc_dec_pair_reg: output holding register with the valid/ready logic. The parent keeps the FSM and assembly.

Test Plan:
- Reset mid-fill: accept 3 words, assert reset=0 → in_ready=0, out_valid=0, outputs 0. After release, 8 words 0x1..0x8 → dataout=0x00000004_00000003_00000002_00000001, dataout1=0x8_7_6_5 packed the same way.
- Continuous stream, out_ready=1: 24 words → three pairs, out_valid pulses 1 cycle each. Each out_valid rises exactly 1 cycle after its pair's 8th word. in_ready is low exactly 1 cycle per pair.
- Backpressure: out_ready=0 with pair 1 held and pair 2 fully assembled → FSM holds XFER, in_ready=0, dataout unchanged. Raising out_ready for one cycle → pair 2 loaded in that same edge, out_valid stays 1.
- Input gaps: toggle in_valid 1/0 each cycle → same packed result as the contiguous case. No word is duplicated or lost.
- (LOADER_PAD_FLUSH_EN) Accept 0xA,0xB, then flush=1 → dataout=0x0_0_B_A, dataout1=0, out_valid=1 next cycle. flush with zero words accepted → no output.
- Handshake corner: out_ready=1 while out_valid=0 → no state change. out_valid held across 100 cycles with out_ready=0 → data stable.
